// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I(+M) decode stage with valid/ready output register, load-use bubbling, flush and writeback bypass
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        fetch handshake; in_instr, in_pc offered instruction
//   out_valid/out_ready      execute handshake for the registered decode bundle
//   flush                    synchronous kill of held and incoming instruction
//   out_pc, rs*_addr, rd_addr, rs*_data, imm, alu_func, alu_src*_sel,
//   reg_write, mem_read, mem_write, branch, jump, wb_sel, illegal   decode bundle
//   wb_we, wb_rd, wb_data    register file write port
module decode_stage #(
    parameter int XLEN      = 32,
    parameter bit ENABLE_M  = 1'b0,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    input  logic            flush,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [4:0]      rd_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm,
    output logic [9:0]      alu_func,
    output logic            alu_src1_sel,
    output logic [1:0]      alu_src2_sel,
    output logic            reg_write,
    output logic            mem_read,
    output logic            mem_write,
    output logic            branch,
    output logic            jump,
    output logic [1:0]      wb_sel,
    output logic            illegal,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALUR   = 7'b0110011;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    // Signed raw immediates; the XLEN size cast sign-extends them.
    logic signed [11:0] raw_i, raw_s;
    logic signed [12:0] raw_b;
    logic signed [31:0] raw_u;
    logic signed [20:0] raw_j;
    assign raw_i = in_instr[31:20];
    assign raw_s = {in_instr[31:25], in_instr[11:7]};
    assign raw_b = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign raw_u = {in_instr[31:12], 12'b0};
    assign raw_j = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

    logic [XLEN-1:0] d_imm;
    logic [9:0]      d_func;
    logic [4:0]      d_rs1;
    logic [1:0]      d_src2, d_wb;
    logic            d_src1, d_rw, d_mr, d_mw, d_br, d_j, d_ill, d_uses_rs2;

    always_comb begin
        d_imm      = '0;
        d_func     = '0;
        d_rs1      = in_instr[19:15];
        d_src1     = 1'b0;
        d_src2     = 2'd0;
        d_wb       = 2'd0;
        d_rw       = 1'b0;
        d_mr       = 1'b0;
        d_mw       = 1'b0;
        d_br       = 1'b0;
        d_j        = 1'b0;
        d_ill      = 1'b0;
        d_uses_rs2 = 1'b0;
        case (opcode)
            OP_LUI: begin
                // LUI is computed as 0 + imm, so rs1 is pinned to x0.
                d_rs1 = 5'd0; d_src2 = 2'd1; d_rw = 1'b1; d_imm = XLEN'(raw_u);
            end
            OP_AUIPC: begin
                d_src1 = 1'b1; d_src2 = 2'd1; d_rw = 1'b1; d_imm = XLEN'(raw_u);
            end
            OP_JAL: begin
                d_j = 1'b1; d_src1 = 1'b1; d_src2 = 2'd1; d_rw = 1'b1; d_wb = 2'd2;
                d_imm = XLEN'(raw_j);
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    d_j = 1'b1; d_src2 = 2'd1; d_rw = 1'b1; d_wb = 2'd2; d_imm = XLEN'(raw_i);
                end else d_ill = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 != 3'b010 && funct3 != 3'b011) begin
                    d_br = 1'b1; d_func = {7'b0, funct3}; d_imm = XLEN'(raw_b); d_uses_rs2 = 1'b1;
                end else d_ill = 1'b1;
            end
            OP_LOAD: begin
                if (funct3 != 3'b011 && funct3 != 3'b110 && funct3 != 3'b111) begin
                    d_mr = 1'b1; d_src2 = 2'd1; d_rw = 1'b1; d_wb = 2'd1; d_imm = XLEN'(raw_i);
                end else d_ill = 1'b1;
            end
            OP_STORE: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010) begin
                    d_mw = 1'b1; d_src2 = 2'd1; d_imm = XLEN'(raw_s); d_uses_rs2 = 1'b1;
                end else d_ill = 1'b1;
            end
            OP_ALUI: begin
                // Shifts carry their funct7 (SRAI vs SRLI) into alu_func.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    if (funct7 == 7'b0000000 || (funct3 == 3'b101 && funct7 == 7'b0100000)) begin
                        d_src2 = 2'd1; d_rw = 1'b1; d_func = {funct7, funct3}; d_imm = XLEN'(raw_i);
                    end else d_ill = 1'b1;
                end else begin
                    d_src2 = 2'd1; d_rw = 1'b1; d_func = {7'b0, funct3}; d_imm = XLEN'(raw_i);
                end
            end
            OP_ALUR: begin
                if (funct7 == 7'b0000000 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                    (funct7 == 7'b0000001 && ENABLE_M)) begin
                    d_rw = 1'b1; d_func = {funct7, funct3}; d_uses_rs2 = 1'b1;
                end else d_ill = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
    end

    // Register file: x0 is never written and always reads zero.
    logic [XLEN-1:0] regs [32];
    always_ff @(posedge clk) begin
        if (wb_we && wb_rd != 5'd0)
            regs[wb_rd] <= wb_data;
    end

    logic [4:0]      d_rs2;
    logic [XLEN-1:0] rd1, rd2;
    assign d_rs2 = in_instr[24:20];

    always_comb begin
        rd1 = (d_rs1 == 5'd0) ? '0 : regs[d_rs1];
        rd2 = (d_rs2 == 5'd0) ? '0 : regs[d_rs2];
        if (WB_BYPASS && wb_we) begin
            if (d_rs1 != 5'd0 && wb_rd == d_rs1) rd1 = wb_data;
            if (d_rs2 != 5'd0 && wb_rd == d_rs2) rd2 = wb_data;
        end
    end

    logic hazard, accept;
    assign hazard = out_valid && mem_read && rd_addr != 5'd0 &&
                    (d_rs1 == rd_addr || (d_uses_rs2 && d_rs2 == rd_addr));
    assign in_ready = !hazard && !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_pc       <= '0;
            rs1_addr     <= '0;
            rs2_addr     <= '0;
            rd_addr      <= '0;
            rs1_data     <= '0;
            rs2_data     <= '0;
            imm          <= '0;
            alu_func     <= '0;
            alu_src1_sel <= 1'b0;
            alu_src2_sel <= '0;
            reg_write    <= 1'b0;
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            branch       <= 1'b0;
            jump         <= 1'b0;
            wb_sel       <= '0;
            illegal      <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid    <= 1'b1;
            out_pc       <= in_pc;
            rs1_addr     <= d_rs1;
            rs2_addr     <= d_rs2;
            rd_addr      <= in_instr[11:7];
            rs1_data     <= rd1;
            rs2_data     <= rd2;
            imm          <= d_imm;
            alu_func     <= d_func;
            alu_src1_sel <= d_src1;
            alu_src2_sel <= d_src2;
            reg_write    <= d_rw;
            mem_read     <= d_mr;
            mem_write    <= d_mw;
            branch       <= d_br;
            jump         <= d_j;
            wb_sel       <= d_wb;
            illegal      <= d_ill;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid && WB_BYPASS && wb_we && wb_rd != 5'd0) begin
            // A held bundle picks up writebacks that land while execute stalls.
            if (wb_rd == rs1_addr) rs1_data <= wb_data;
            if (wb_rd == rs2_addr) rs2_data <= wb_data;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - scoreboard bench for decode_stage (default params plus ENABLE_M=1/WB_BYPASS=0 copy)
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst, in_valid, out_ready, flush, wb_we;
    logic [31:0] in_instr, in_pc, wb_data;
    logic [4:0]  wb_rd;

    logic        in_ready, out_valid, alu_src1_sel, reg_write, mem_read, mem_write, branch, jump, illegal;
    logic [31:0] out_pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [9:0]  alu_func;
    logic [1:0]  alu_src2_sel, wb_sel;

    logic        m_in_ready, m_out_valid, m_alu_src1_sel, m_reg_write, m_mem_read, m_mem_write;
    logic        m_branch, m_jump, m_illegal;
    logic [31:0] m_out_pc, m_rs1_data, m_rs2_data, m_imm;
    logic [4:0]  m_rs1_addr, m_rs2_addr, m_rd_addr;
    logic [9:0]  m_alu_func;
    logic [1:0]  m_alu_src2_sel, m_wb_sel;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .out_pc(out_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .alu_func(alu_func),
        .alu_src1_sel(alu_src1_sel), .alu_src2_sel(alu_src2_sel), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
        .wb_sel(wb_sel), .illegal(illegal), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    decode_stage #(.XLEN(32), .ENABLE_M(1'b1), .WB_BYPASS(1'b0)) dut_m (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(m_in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .out_valid(m_out_valid), .out_ready(out_ready), .flush(flush),
        .out_pc(m_out_pc), .rs1_addr(m_rs1_addr), .rs2_addr(m_rs2_addr), .rd_addr(m_rd_addr),
        .rs1_data(m_rs1_data), .rs2_data(m_rs2_data), .imm(m_imm), .alu_func(m_alu_func),
        .alu_src1_sel(m_alu_src1_sel), .alu_src2_sel(m_alu_src2_sel), .reg_write(m_reg_write),
        .mem_read(m_mem_read), .mem_write(m_mem_write), .branch(m_branch), .jump(m_jump),
        .wb_sel(m_wb_sel), .illegal(m_illegal), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc, imm, d1, d2;
        logic [4:0]  rs1, rs2, rd;
        logic [9:0]  func;
        logic        s1, rw, mr, mw, br, j, ill;
        logic [1:0]  s2, wb;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [31:0] mdl [32];
    logic [31:0] old3, old6;
    int          vectors = 0;
    int          errors  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rdm(input logic [4:0] a);
        return (a == 5'd0) ? 32'd0 : mdl[a];
    endfunction

    // Default bundle: fields from the instruction, operands from the model, all controls clear.
    function automatic exp_t base(input logic [31:0] pc, input logic [31:0] ins);
        exp_t b;
        b.pc = pc; b.rs1 = ins[19:15]; b.rs2 = ins[24:20]; b.rd = ins[11:7];
        b.d1 = rdm(ins[19:15]); b.d2 = rdm(ins[24:20]);
        b.imm = 0; b.func = 0; b.s1 = 0; b.s2 = 0; b.wb = 0;
        b.rw = 0; b.mr = 0; b.mw = 0; b.br = 0; b.j = 0; b.ill = 0;
        return b;
    endfunction

    task automatic present(input logic [31:0] pc, input logic [31:0] ins);
        in_valid = 1'b1; in_pc = pc; in_instr = ins;
    endtask

    task automatic compare_bundle(input string tag);
        exp_t x;
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
        vectors++;
        assert (q.size() != 0) else begin
            errors++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end
        if (q.size() != 0) begin
            x = q.pop_front();
            chk({tag, "_pc"},       out_pc,                 x.pc);
            chk({tag, "_rs1_addr"}, {27'd0, rs1_addr},      {27'd0, x.rs1});
            chk({tag, "_rs2_addr"}, {27'd0, rs2_addr},      {27'd0, x.rs2});
            chk({tag, "_rd_addr"},  {27'd0, rd_addr},       {27'd0, x.rd});
            chk({tag, "_rs1_data"}, rs1_data,               x.d1);
            chk({tag, "_rs2_data"}, rs2_data,               x.d2);
            chk({tag, "_imm"},      imm,                    x.imm);
            chk({tag, "_alu_func"}, {22'd0, alu_func},      {22'd0, x.func});
            chk({tag, "_src1"},     {31'd0, alu_src1_sel},  {31'd0, x.s1});
            chk({tag, "_src2"},     {30'd0, alu_src2_sel},  {30'd0, x.s2});
            chk({tag, "_wb_sel"},   {30'd0, wb_sel},        {30'd0, x.wb});
            chk({tag, "_flags"},
                {26'd0, reg_write, mem_read, mem_write, branch, jump, illegal},
                {26'd0, x.rw, x.mr, x.mw, x.br, x.j, x.ill});
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        out_ready = 1'b1; wb_we = 1'b0; wb_rd = '0; wb_data = '0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
        repeat (3) cycle();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_imm", imm, 32'd0);
        chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
        chk("rst_out_pc", out_pc, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Fill the register file; the x0 write must be ignored.
        for (int i = 0; i < 32; i++) begin
            wb_we = 1'b1; wb_rd = i[4:0];
            wb_data = (i == 0) ? 32'hFFFF_FFFF : (32'hA000_0000 | i);
            if (i != 0) mdl[i] = 32'hA000_0000 | i;
            cycle();
        end
        wb_we = 1'b0;

        // ADDI x1,x0,5
        e = base(32'h100, 32'h00500093); e.imm = 5; e.s2 = 1; e.rw = 1; q.push_back(e);
        present(32'h100, 32'h00500093);
        cycle(); in_valid = 1'b0;
        compare_bundle("addi");
        wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; mdl[1] = 32'd5;
        cycle();
        wb_rd = 5'd2; wb_data = 32'hDEADBEEF; mdl[2] = 32'hDEADBEEF;
        cycle(); wb_we = 1'b0;

        // SW x2,-4(x1)
        e = base(32'h104, 32'hFE20AE23); e.imm = 32'hFFFF_FFFC; e.s2 = 1; e.mw = 1; q.push_back(e);
        present(32'h104, 32'hFE20AE23);
        cycle(); in_valid = 1'b0;
        compare_bundle("sw");
        cycle();

        // LW x3,0(x1) then ADD x4,x3,x3: one bubble, then ADD with x3 bypassed on its accepting edge
        e = base(32'h108, 32'h0000A183); e.s2 = 1; e.rw = 1; e.mr = 1; e.wb = 1; q.push_back(e);
        present(32'h108, 32'h0000A183);
        cycle();
        compare_bundle("lw");
        present(32'h10C, 32'h00318233);
        #1;
        chk("hazard_in_ready", {31'd0, in_ready}, 32'd0);
        e = base(32'h10C, 32'h00318233); e.rw = 1; e.d1 = 32'h33; e.d2 = 32'h33; q.push_back(e);
        cycle();
        chk("bubble_out_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);
        old3 = mdl[3];
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h33;
        cycle(); in_valid = 1'b0; wb_we = 1'b0;
        compare_bundle("add_after_bubble");
        chk("nobypass_read_old", m_rs1_data, old3);
        mdl[3] = 32'h33;

        // ADD x5,x6,x7 held; writeback of x6 updates held operand only with bypass
        e = base(32'h110, 32'h007302B3); e.rw = 1; q.push_back(e);
        present(32'h110, 32'h007302B3);
        cycle(); in_valid = 1'b0; out_ready = 1'b0;
        compare_bundle("add_hold");
        old6 = mdl[6];
        wb_we = 1'b1; wb_rd = 5'd6; wb_data = 32'h1234;
        cycle(); wb_we = 1'b0; mdl[6] = 32'h1234;
        chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_bypass_rs1", rs1_data, 32'h1234);
        chk("hold_bypass_rs2", rs2_data, mdl[7]);
        chk("hold_nobypass_rs1", m_rs1_data, old6);

        // Flush with held bundle and incoming ADDI x9,x0,9
        present(32'h114, 32'h00900493); flush = 1'b1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        cycle(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        cycle();
        chk("flush_not_captured", {31'd0, out_valid}, 32'd0);

        // Back-to-back stream: all-ones, MUL, JAL, BEQ
        e = base(32'h200, 32'hFFFF_FFFF); e.ill = 1; q.push_back(e);
        present(32'h200, 32'hFFFF_FFFF);
        cycle();
        compare_bundle("all_ones");
        chk("all_ones_m_illegal", {31'd0, m_illegal}, 32'd1);

        e = base(32'h204, 32'h023100B3); e.ill = 1; q.push_back(e);
        present(32'h204, 32'h023100B3);
        cycle();
        compare_bundle("mul_no_m");
        chk("mul_m_illegal", {31'd0, m_illegal}, 32'd0);
        chk("mul_m_alu_func", {22'd0, m_alu_func}, 32'h008);
        chk("mul_m_reg_write", {31'd0, m_reg_write}, 32'd1);

        e = base(32'h208, 32'h008000EF); e.imm = 8; e.s1 = 1; e.s2 = 1; e.rw = 1; e.j = 1; e.wb = 2;
        q.push_back(e);
        present(32'h208, 32'h008000EF);
        cycle();
        compare_bundle("jal");

        e = base(32'h20C, 32'hFE208CE3); e.imm = 32'hFFFF_FFF8; e.br = 1; q.push_back(e);
        present(32'h20C, 32'hFE208CE3);
        cycle(); in_valid = 1'b0;
        compare_bundle("beq");
        cycle();

        // Reset while a bundle is held
        present(32'h300, 32'h00900493); out_ready = 1'b0;
        cycle(); in_valid = 1'b0;
        chk("pre_rst_held", {31'd0, out_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_imm", imm, 32'd0);
        cycle(); rst = 1'b0; out_ready = 1'b1;
        chk("sb_drained", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
